// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues the current PC to instruction memory, tracks outstanding requests
// with a PC tag queue, and buffers returned instructions for decode in a small FIFO.
module instr_fetch_queue #(
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [DWIDTH-1:0] Program_Count,
  output logic              Pc_Advance,
  input  logic              Fetch_Flush,
  output logic              Imem_Req_Valid,
  input  logic              Imem_Req_Ready,
  output logic [DWIDTH-1:0] Imem_Req_Addr,
  input  logic              Imem_Rsp_Valid,
  input  logic [DWIDTH-1:0] Imem_Rsp_Data,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  output logic [DWIDTH-1:0] Inst_Data,
  output logic [DWIDTH-1:0] Inst_PC
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [CW-1:0]     count_q, count_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]     inflight_q, inflight_d, discard_q, discard_d, live;
  logic [TW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [DWIDTH-1:0] head_data_q, head_data_d, head_pc_q, head_pc_d;
  logic              rst_hold_q;

  logic [DWIDTH-1:0] data_mem [DEPTH];
  logic [DWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] tag_mem  [MAX_OUT];

  logic req_valid, accept, push, pop;
  logic [DWIDTH-1:0] rsp_pc;

  // Credit check: every request that will return live data already owns a FIFO slot.
  assign live      = inflight_q - discard_q;
  assign req_valid = !Rst_Core && !rst_hold_q && !Fetch_Flush &&
                     (int'(inflight_q) < MAX_OUT) &&
                     ((int'(count_q) + int'(live)) < DEPTH);
  assign accept    = req_valid && Imem_Req_Ready;
  assign push      = Imem_Rsp_Valid && (discard_q == '0) && !Fetch_Flush;
  assign pop       = (count_q != '0) && Inst_Ready && !Fetch_Flush;
  assign rsp_pc    = tag_mem[tag_rd_q];

  assign Imem_Req_Valid = req_valid;
  assign Pc_Advance     = accept;
  assign Imem_Req_Addr  = Program_Count;
  assign Inst_Valid     = (count_q != '0);
  assign Inst_Data      = head_data_q;
  assign Inst_PC        = head_pc_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    discard_d   = discard_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    inflight_d  = inflight_q + IW'(accept) - IW'(Imem_Rsp_Valid);

    if (accept) begin
      tag_wr_d = (tag_wr_q == TW'(MAX_OUT - 1)) ? '0 : tag_wr_q + 1'b1;
    end
    if (Imem_Rsp_Valid) begin
      tag_rd_d = (tag_rd_q == TW'(MAX_OUT - 1)) ? '0 : tag_rd_q + 1'b1;
      if (discard_q != '0) discard_d = discard_q - 1'b1;
    end

    if (Fetch_Flush) begin
      // Everything still outstanding after this cycle's response is stale.
      count_d   = '0;
      rd_ptr_d  = wr_ptr_q;
      discard_d = inflight_d;
    end else begin
      wr_ptr_d = wr_ptr_q + CW'(push);
      rd_ptr_d = rd_ptr_q + CW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push && ((count_q - CW'(pop)) == '0)) begin
        head_data_d = Imem_Rsp_Data;
        head_pc_d   = rsp_pc;
      end else if (count_d != '0) begin
        head_data_d = data_mem[rd_ptr_d[AW-1:0]];
        head_pc_d   = pc_mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      rst_hold_q  <= 1'b1;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      rst_hold_q  <= 1'b0;
      if (Imem_Rsp_Valid) assert (inflight_q != '0);
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (accept) tag_mem[tag_wr_q] <= Program_Count;
    if (push && !Rst_Core) begin
      data_mem[wr_ptr_q[AW-1:0]] <= Imem_Rsp_Data;
      pc_mem[wr_ptr_q[AW-1:0]]   <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and randomized stimulus for instr_fetch_queue, compared every cycle with a
// queue-based reference model of the fetch pipeline and its instruction memory.
module tb_instr_fetch_queue;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;

  logic          Clk_Core = 1'b0;
  logic          Rst_Core;
  logic [DW-1:0] Program_Count;
  logic          Pc_Advance;
  logic          Fetch_Flush;
  logic          Imem_Req_Valid;
  logic          Imem_Req_Ready;
  logic [DW-1:0] Imem_Req_Addr;
  logic          Imem_Rsp_Valid;
  logic [DW-1:0] Imem_Rsp_Data;
  logic          Inst_Valid;
  logic          Inst_Ready;
  logic [DW-1:0] Inst_Data;
  logic [DW-1:0] Inst_PC;

  always #5 Clk_Core = ~Clk_Core;

  instr_fetch_queue #(.DWIDTH(DW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .Clk_Core(Clk_Core), .Rst_Core(Rst_Core), .Program_Count(Program_Count),
    .Pc_Advance(Pc_Advance), .Fetch_Flush(Fetch_Flush), .Imem_Req_Valid(Imem_Req_Valid),
    .Imem_Req_Ready(Imem_Req_Ready), .Imem_Req_Addr(Imem_Req_Addr),
    .Imem_Rsp_Valid(Imem_Rsp_Valid), .Imem_Rsp_Data(Imem_Rsp_Data),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst_Data(Inst_Data),
    .Inst_PC(Inst_PC)
  );

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          fifo_m[$];   // instructions waiting for decode
  ent_t          imem_m[$];   // accepted requests the memory still owes
  int            stale_m;     // leading imem_m entries that belong to flushed fetches
  logic [DW-1:0] pc_m;
  bit            blk_m;       // first cycle after reset issues nothing
  int            checks, errors;
  int            adv_cnt, vcnt;
  bit            want_first;
  logic [DW-1:0] first_pc;

  function automatic logic [DW-1:0] memf(input logic [DW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit fl, input bit rr, input bit rv, input bit ir,
                     input logic [DW-1:0] redir);
    bit   rsp, exp_rv, acc;
    ent_t e;
    rsp            = rv && (imem_m.size() > 0);
    Fetch_Flush    = fl;
    Imem_Req_Ready = rr;
    Imem_Rsp_Valid = rsp;
    Imem_Rsp_Data  = rsp ? imem_m[0].data : $urandom;
    Inst_Ready     = ir;
    Program_Count  = pc_m;
    #4;
    exp_rv = !blk_m && !fl && (imem_m.size() < MAX_OUT) &&
             ((fifo_m.size() + imem_m.size() - stale_m) < DEPTH);
    acc = exp_rv && rr;
    chk("req_valid", Imem_Req_Valid, exp_rv);
    chk("pc_advance", Pc_Advance, acc);
    chk("req_addr", Imem_Req_Addr, pc_m);
    chk("inst_valid", Inst_Valid, fifo_m.size() != 0);
    if (fifo_m.size() != 0) begin
      chk("inst_pc", Inst_PC, fifo_m[0].pc);
      chk("inst_data", Inst_Data, fifo_m[0].data);
    end
    if (Pc_Advance) adv_cnt++;
    if (Inst_Valid) vcnt++;
    if (want_first && Inst_Valid) begin
      first_pc   = Inst_PC;
      want_first = 1'b0;
    end
    if (!fl && (fifo_m.size() != 0) && ir) void'(fifo_m.pop_front());
    if (rsp) begin
      e = imem_m.pop_front();
      if (stale_m > 0) stale_m--;
      else if (!fl) fifo_m.push_back(e);
    end
    if (fl) begin
      fifo_m.delete();
      stale_m = imem_m.size();
    end
    if (acc) begin
      imem_m.push_back('{pc: pc_m, data: memf(pc_m)});
      pc_m = pc_m + 32'd4;
    end
    if (fl) pc_m = redir;
    blk_m = 1'b0;
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic do_reset();
    Rst_Core       = 1'b1;
    Fetch_Flush    = 1'b0;
    Imem_Req_Ready = 1'b0;
    Imem_Rsp_Valid = 1'b0;
    Inst_Ready     = 1'b0;
    @(posedge Clk_Core);
    #1;
    Rst_Core = 1'b0;
    fifo_m.delete();
    imem_m.delete();
    stale_m        = 0;
    pc_m           = '0;
    blk_m          = 1'b1;
    adv_cnt        = 0;
    Imem_Req_Ready = 1'b1;
    Inst_Ready     = 1'b1;
    Program_Count  = '0;
    #1;
    chk("rst_req_valid", Imem_Req_Valid, 1'b0);
    chk("rst_pc_advance", Pc_Advance, 1'b0);
    chk("rst_inst_valid", Inst_Valid, 1'b0);
    chk("rst_inst_data", Inst_Data, '0);
    chk("rst_inst_pc", Inst_PC, '0);
  endtask

  initial begin
    checks = 0; errors = 0; want_first = 1'b0; first_pc = '0;
    Rst_Core = 1'b1; Fetch_Flush = 1'b0; Imem_Req_Ready = 1'b0;
    Imem_Rsp_Valid = 1'b0; Imem_Rsp_Data = '0; Inst_Ready = 1'b0; Program_Count = '0;

    // Streaming: one instruction per cycle in steady state
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, '0);
    vcnt = 0;
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, '0);
    chk("t1_rate", vcnt, 6);

    // Decode stalled: credit stops fetch after DEPTH accepts, then drain and resume
    do_reset();
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, '0);
    chk("t2_accepts", adv_cnt, 4);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, '0);
    chk("t2_resumed", adv_cnt > 4, 1'b1);

    // Memory not ready: no PC advance
    adv_cnt = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, '0);
    chk("t3_noadv", adv_cnt, 0);

    // Flush with two requests in flight, redirect to 0x100
    do_reset();
    pc_m = 32'h20;
    cyc(0, 1, 0, 1, '0);
    cyc(0, 1, 0, 1, '0);
    cyc(0, 1, 0, 1, '0);
    want_first = 1'b1;
    cyc(1, 0, 0, 1, 32'h100);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, '0);
    chk("t4_first_pc", first_pc, 32'h100);

    // Flush coinciding with a response and a decode pop
    do_reset();
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, '0);
    cyc(0, 1, 0, 0, '0);
    cyc(1, 0, 1, 1, 32'h200);
    chk("t5_novalid", Inst_Valid, 1'b0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 1, '0);

    // Reset with a partly full FIFO and requests outstanding
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, '0);
    cyc(0, 1, 0, 0, '0);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 1, '0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
          {22'd0, 8'($urandom_range(0, 255)), 2'b00});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
